// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC select codes, PC width.
package pc_seq_pkg;

    localparam int unsigned PC_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JALR   = 2'd2
    } next_sel_t;

endpackage

// File: rtl/Adder.sv
// Plain modulo-2^WIDTH adder shared by the PC datapath.
module Adder #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_next_gen.sv
// Combinational next-PC target generator (PC+4, branch, JALR).
// The misaligned flag port exists only when PC_TRAP_EN is defined.
module pc_next_gen
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_immediate,
    input  logic [PC_W-1:0] i_jalr_target,
    input  next_sel_t       i_sel,
    output logic [PC_W-1:0] o_target,
    output logic [PC_W-1:0] o_pc_plus4
`ifdef PC_TRAP_EN
    ,
    output logic            o_misaligned
`endif
);

    logic [PC_W-1:0] w_branch_off;
    logic [PC_W-1:0] w_branch_target;

    // Immediate is in halfwords; the shifted-out top bit is discarded (mod 2^64).
    assign w_branch_off = i_immediate << 1;

    Adder #(.WIDTH(PC_W)) u_add_seq (
        .i_a   (i_pc),
        .i_b   (PC_W'(4)),
        .o_sum (o_pc_plus4)
    );

    Adder #(.WIDTH(PC_W)) u_add_branch (
        .i_a   (i_pc),
        .i_b   (w_branch_off),
        .o_sum (w_branch_target)
    );

    always_comb begin
        o_target = o_pc_plus4;
        case (i_sel)
            SEL_BRANCH: o_target = w_branch_target;
            SEL_JALR:   o_target = i_jalr_target & ~PC_W'(1);
            default:    o_target = o_pc_plus4;
        endcase
    end

`ifdef PC_TRAP_EN
    assign o_misaligned = |o_target[1:0];
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC fetch/update controller: IDLE -> FETCH -> EXEC -> UPDATE -> (FETCH | HALT).
// Optional misaligned-target trap redirect enabled by defining PC_TRAP_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0
`ifdef PC_TRAP_EN
    ,
    parameter logic [63:0] TRAP_VECTOR = 64'h100
`endif
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_issue,
    input  logic        ex_done,
    input  logic        branch_taken,
    input  logic        is_jalr,
    input  logic [63:0] immediate,
    input  logic [63:0] jalr_target,
    input  logic        halt,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        pc_we,
    output logic        halted
`ifdef PC_TRAP_EN
    ,
    output logic        trap
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_next_pc_q;
    logic            r_halt_q;
    next_sel_t       w_sel;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_plus4;
`ifdef PC_TRAP_EN
    logic            r_trap_q;
    logic            w_misaligned;
`endif

    assign w_sel = is_jalr      ? SEL_JALR   :
                   branch_taken ? SEL_BRANCH : SEL_SEQ;

    pc_next_gen u_next_gen (
        .i_pc          (r_pc),
        .i_immediate   (immediate),
        .i_jalr_target (jalr_target),
        .i_sel         (w_sel),
        .o_target      (w_target),
        .o_pc_plus4    (w_pc_plus4)
`ifdef PC_TRAP_EN
        ,
        .o_misaligned  (w_misaligned)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = ST_FETCH;
            ST_FETCH:  if (imem_ready) w_state_nxt = ST_EXEC;
            ST_EXEC:   if (ex_done) w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = r_halt_q ? ST_HALT : ST_FETCH;
            ST_HALT:   w_state_nxt = ST_HALT;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == ST_FETCH);
        instr_issue = (r_state == ST_FETCH) & imem_ready;
        pc_we       = (r_state == ST_UPDATE);
        halted      = (r_state == ST_HALT);
`ifdef PC_TRAP_EN
        trap        = (r_state == ST_UPDATE) & r_trap_q;
`endif
    end

    // Target is captured at ex_done so UPDATE commits it even if control inputs move on.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_next_pc_q <= '0;
            r_halt_q    <= 1'b0;
`ifdef PC_TRAP_EN
            r_trap_q    <= 1'b0;
`endif
        end else begin
            if (r_state == ST_EXEC && ex_done) begin
                r_halt_q    <= halt;
`ifdef PC_TRAP_EN
                r_next_pc_q <= w_misaligned ? TRAP_VECTOR : w_target;
                r_trap_q    <= w_misaligned;
`else
                r_next_pc_q <= w_target;
`endif
            end
            if (r_state == ST_UPDATE) begin
                r_pc <= r_next_pc_q;
            end
        end
    end

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign pc_plus4  = w_pc_plus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: cycle-level reference model plus directed literal checks.
// Build with PC_TRAP_EN defined to exercise the trap redirect.
module tb_pc_sequencer;

    localparam logic [63:0] RST_PC   = 64'h0;
    localparam logic [63:0] TRAP_VEC = 64'h100;

    localparam int PH_IDLE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_EXEC   = 2;
    localparam int PH_UPDATE = 3;
    localparam int PH_HALT   = 4;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic        instr_issue;
    logic        ex_done;
    logic        branch_taken;
    logic        is_jalr;
    logic [63:0] immediate;
    logic [63:0] jalr_target;
    logic        halt;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        pc_we;
    logic        halted;
`ifdef PC_TRAP_EN
    logic        trap;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .instr_issue  (instr_issue),
        .ex_done      (ex_done),
        .branch_taken (branch_taken),
        .is_jalr      (is_jalr),
        .immediate    (immediate),
        .jalr_target  (jalr_target),
        .halt         (halt),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .pc_we        (pc_we),
        .halted       (halted)
`ifdef PC_TRAP_EN
        ,
        .trap         (trap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the instruction phase and the architectural PC.
    int          m_phase = PH_IDLE;
    bit          m_valid = 1'b0;
    logic [63:0] m_pc    = '0;
    logic [63:0] m_npc   = '0;
    bit          m_halt  = 1'b0;
    bit          m_trap  = 1'b0;

    always @(negedge clk) begin
        logic [63:0] t;
        if (m_valid) begin
            check("m_imem_req", imem_req, m_phase == PH_FETCH);
            check("m_issue", instr_issue, (m_phase == PH_FETCH) && imem_ready);
            check("m_pc_we", pc_we, m_phase == PH_UPDATE);
            check("m_halted", halted, m_phase == PH_HALT);
            check("m_pc", pc, m_pc);
            check("m_imem_addr", imem_addr, m_pc);
            check("m_pc_plus4", pc_plus4, m_pc + 64'd4);
`ifdef PC_TRAP_EN
            check("m_trap", trap, (m_phase == PH_UPDATE) && m_trap);
`endif
        end
        if (reset) begin
            m_valid = 1'b1;
            m_phase = PH_IDLE;
            m_pc    = RST_PC;
            m_npc   = '0;
            m_halt  = 1'b0;
            m_trap  = 1'b0;
        end else if (m_valid) begin
            case (m_phase)
                PH_IDLE:  m_phase = PH_FETCH;
                PH_FETCH: if (imem_ready) m_phase = PH_EXEC;
                PH_EXEC: if (ex_done) begin
                    if (is_jalr)           t = jalr_target - (jalr_target % 2);
                    else if (branch_taken) t = m_pc + immediate * 2;
                    else                   t = m_pc + 4;
                    m_trap = 1'b0;
`ifdef PC_TRAP_EN
                    if (t % 4 != 0) begin
                        t      = TRAP_VEC;
                        m_trap = 1'b1;
                    end
`endif
                    m_npc   = t;
                    m_halt  = halt;
                    m_phase = PH_UPDATE;
                end
                PH_UPDATE: begin
                    m_pc    = m_npc;
                    m_phase = m_halt ? PH_HALT : PH_FETCH;
                end
                default: ;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_instr();
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; ex_done = 1'b0; branch_taken = 1'b0;
        is_jalr = 1'b0; immediate = '0; jalr_target = '0; halt = 1'b0;
        tick(); tick();
        check("rst_pc", pc, 64'h0);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_halted", halted, 1'b0);
        reset = 1'b0;
        tick();
        check("fetch_after_reset", imem_req, 1'b1);

        imem_ready = 1'b1; ex_done = 1'b1;
        step_instr(); check("seq_pc4", pc, 64'h4);
        step_instr(); check("seq_pc8", pc, 64'h8);
        step_instr(); check("seq_pc12", pc, 64'hC);
        step_instr(); check("seq_pc16", pc, 64'h10);

        branch_taken = 1'b1; immediate = 64'd8;
        tick(); check("exec_pc_plus4", pc_plus4, 64'h14);
        tick(); tick(); check("branch_pc", pc, 64'h20);

        branch_taken = 1'b0; is_jalr = 1'b1; jalr_target = 64'h1235;
        step_instr(); check("jalr_pc", pc, 64'h1234);

        jalr_target = 64'h1236;
        tick(); tick();
`ifdef PC_TRAP_EN
        check("trap_pulse", trap, 1'b1);
        tick(); check("trap_pc", pc, 64'h100);
        check("trap_clear", trap, 1'b0);
`else
        tick(); check("jalr_unaligned_pc", pc, 64'h1236);
`endif

        jalr_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step_instr(); check("jalr_top_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        is_jalr = 1'b0;
        step_instr(); check("wrap_pc", pc, 64'h0);

        branch_taken = 1'b1; immediate = 64'hFFFF_FFFF_FFFF_FFFE;
        step_instr(); check("neg_branch_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        branch_taken = 1'b0;

        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_req", imem_req, 1'b1);
            check("stall_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
            check("stall_issue", instr_issue, 1'b0);
        end
        imem_ready = 1'b1;
        #1 check("ready_issue", instr_issue, 1'b1);
        tick();
        imem_ready = 1'b0; ex_done = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("midexec_rst_pc", pc, RST_PC);
        check("midexec_rst_req", imem_req, 1'b0);
        check("midexec_rst_we", pc_we, 1'b0);
        reset = 1'b0; imem_ready = 1'b1; ex_done = 1'b1;
        tick();
        step_instr(); step_instr();
        check("pre_halt_pc", pc, 64'h8);
        halt = 1'b1;
        step_instr();
        check("halt_pc", pc, 64'hC);
        check("halt_flag", halted, 1'b1);
        halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            ex_done    = 1'($urandom_range(0, 1));
            tick();
            check("halt_hold_pc", pc, 64'hC);
            check("halt_hold_flag", halted, 1'b1);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0; imem_ready = 1'b1; ex_done = 1'b1;
        tick();
        branch_taken = 1'b1; immediate = 64'h40; halt = 1'b1;
        step_instr();
        check("halt_branch_pc", pc, 64'h80);
        check("halt_branch_flag", halted, 1'b1);
        branch_taken = 1'b0; halt = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/update controller for the sequential processor's program counter. Owns the 64-bit PC register and decides when it advances and from which source: PC+4, branch target PC+(imm<<1), or JALR target. Handshakes with instruction memory on the fetch side and with the execute datapath on the completion side. Sits between the instruction-memory interface and the decode/execute datapath.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- TRAP_VECTOR, 64'h100, redirect target for misaligned fetch (used only with PC_TRAP_EN)

- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request, high throughout FETCH
- imem_addr  out  64  equals pc
- imem_ready  in  1  instruction word valid this cycle
- instr_issue  out  1  one-cycle pulse: instruction accepted, execute may start
- ex_done  in  1  datapath finished current instruction; control inputs valid this cycle
- branch_taken  in  1  conditional branch/JAL taken
- is_jalr  in  1  current instruction is JALR
- immediate  in  64  sign-extended branch offset in halfwords
- jalr_target  in  64  rs1+imm from ALU
- halt  in  1  stop after current instruction (ECALL/EBREAK)
- pc  out  64  current PC
- pc_plus4  out  64  pc+4 for link writeback
- pc_we  out  1  high in UPDATE
- halted  out  1  high in HALT
- trap  out  1  only with PC_TRAP_EN: one-cycle pulse in UPDATE on misaligned target

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, HALT.
- IDLE: entered on reset; -> FETCH next cycle unconditionally.
- FETCH: imem_req=1. imem_ready=1 -> EXEC, instr_issue pulses in the same cycle. Otherwise stay.
- EXEC: wait for ex_done. On ex_done=1, latch next_pc_q and halt_q, -> UPDATE.
- next_pc priority: is_jalr -> {jalr_target[63:1],1'b0}; else branch_taken -> pc + (immediate<<1); else pc+4.
- UPDATE: pc <= next_pc_q, pc_we=1. -> HALT if halt_q, else FETCH.
- HALT: hold pc; halted=1; leave only by reset.
- Arithmetic is 64-bit modulo 2^64. Wrap at 64'hFFFF_FFFF_FFFF_FFFC + 4 yields 0 with no flag.
- imem_ready outside FETCH and ex_done outside EXEC are ignored.
- halt together with a taken branch: PC still updates to the branch target, then HALT.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr_issue=0, pc_we=0, halted=0, trap=0, next_pc_q=0, halt_q=0.
- reset takes priority over every transition in every state, including mid-EXEC.
- Minimum 3 cycles per instruction (FETCH, EXEC, UPDATE), with imem_ready and ex_done both high on first sight.
- Each imem_ready-low cycle adds 1 cycle. Each ex_done-low cycle adds 1 cycle.
- pc changes only on the edge that ends UPDATE.
- imem_req, pc_we, halted and trap are decoded from registered state. No combinational path from inputs to these outputs.
- instr_issue = (state==FETCH) & imem_ready (combinational).

## Configuration
- PC_TRAP_EN defined: in EXEC, if the selected target has [1:0] != 0, next_pc_q = TRAP_VECTOR and a trap flag is latched. trap pulses for one cycle in UPDATE.
- PC_TRAP_EN undefined: the trap port is absent and the target is loaded unchanged, except for the JALR bit-0 clear.

## Structure
- Shared package pc_seq_pkg:
  - state enum (IDLE/FETCH/EXEC/UPDATE/HALT)
  - 2-bit next-PC select codes (SEQ/BRANCH/JALR)
  - PC width constant 64
- One sub-module pc_next_gen: combinational. Takes pc, immediate, jalr_target, select and produces the target plus a misaligned flag. Reuses the existing Adder for pc+4 and pc+(imm<<1).

## Test plan
- Reset with RESET_PC=0 -> pc=0, imem_req=0. One cycle after reset falls, imem_req=1.
- imem_ready and ex_done held 1, no branches -> pc steps 0,4,8,12. A pc_we pulse occurs every 3 cycles.
- At pc=0x10, branch_taken=1, immediate=8 -> pc=0x20 after UPDATE. pc_plus4 reads 0x14 during EXEC.
- is_jalr=1, jalr_target=0x1235 -> pc=0x1234. With PC_TRAP_EN and jalr_target=0x1236 -> pc=0x100 and trap pulses once.
- imem_ready low for 5 cycles in FETCH -> imem_req stays high, pc is unchanged, and instr_issue fires only on the ready cycle. Then assert reset mid-EXEC -> next cycle is IDLE with pc=RESET_PC.
- halt=1 with ex_done at pc=0x8 -> pc=0xC and halted=1. Further imem_ready/ex_done activity leaves pc unchanged for 10 cycles.
